// File: rtl/axi_lite_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_regs_pkg
// Description : Shared types, response codes and the byte-lane merge helper
//               for the AXI-Lite register-bank subordinate.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_lite_regs_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_e;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_e;

    // Sized for the widest supported bus (64 bits / 8 lanes); narrower
    // callers zero-extend their operands and truncate the result.
    function automatic logic [63:0] strb_merge(
        input logic [63:0] old_val,
        input logic [63:0] new_val,
        input logic [7:0]  strb
    );
        logic [63:0] res;
        res = old_val;
        for (int b = 0; b < 8; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_if.sv
`default_nettype none
// ============================================================================
// Module      : AXI_LITE
// Description : AXI-Lite link bundle (aw/w/b/ar/r) with Master and Slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface AXI_LITE #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32
);
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic [2:0]                  aw_prot;
    logic                        aw_valid;
    logic                        aw_ready;
    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                        w_valid;
    logic                        w_ready;
    logic [1:0]                  b_resp;
    logic                        b_valid;
    logic                        b_ready;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic [2:0]                  ar_prot;
    logic                        ar_valid;
    logic                        ar_ready;
    logic [AXI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                  r_resp;
    logic                        r_valid;
    logic                        r_ready;

    modport Master (
        output aw_addr, aw_prot, aw_valid, input aw_ready,
        output w_data, w_strb, w_valid, input w_ready,
        input  b_resp, b_valid, output b_ready,
        output ar_addr, ar_prot, ar_valid, input ar_ready,
        input  r_data, r_resp, r_valid, output r_ready
    );

    modport Slave (
        input  aw_addr, aw_prot, aw_valid, output aw_ready,
        input  w_data, w_strb, w_valid, output w_ready,
        output b_resp, b_valid, input b_ready,
        input  ar_addr, ar_prot, ar_valid, output ar_ready,
        output r_data, r_resp, r_valid, input r_ready
    );
endinterface
`default_nettype wire

// File: rtl/axi_lite_regs_slv.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_regs_slv
// Description : AXI-Lite subordinate backed by NUM_REGS data-wide registers.
//               Out-of-range accesses answer SLVERR (reads return zero).
// Ports       : clk_i    - clock, rising edge
//               rst_i    - synchronous active-high reset
//               slv      - AXI-Lite subordinate port
//               reg_o    - register contents, reg k at [k*DW +: DW]
//               reg_wr_o - one-cycle pulse after a committed write to reg k
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_regs_slv
    import axi_lite_regs_pkg::*;
#(
    parameter int unsigned               AXI_ADDR_WIDTH = 32,
    parameter int unsigned               AXI_DATA_WIDTH = 32,
    parameter int unsigned               NUM_REGS       = 8,
    parameter logic [AXI_DATA_WIDTH-1:0] RST_VAL        = '0
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    AXI_LITE.Slave                             slv,
    output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] reg_o,
    output logic [NUM_REGS-1:0]                reg_wr_o
);

    localparam int unsigned c_STRB_W   = AXI_DATA_WIDTH / 8;
    localparam int unsigned c_ADDR_LSB = $clog2(c_STRB_W);
    localparam int unsigned c_IDX_W    = AXI_ADDR_WIDTH - c_ADDR_LSB;
    localparam logic [c_IDX_W-1:0] c_NUM_REGS_IDX = c_IDX_W'(NUM_REGS);

    generate
        if (slv.AXI_DATA_WIDTH != AXI_DATA_WIDTH) begin : g_chk_dw
            $error("axi_lite_regs_slv: interface data width mismatch");
        end
        if (slv.AXI_ADDR_WIDTH != AXI_ADDR_WIDTH) begin : g_chk_aw
            $error("axi_lite_regs_slv: interface address width mismatch");
        end
        if (NUM_REGS < 1) begin : g_chk_num
            $error("axi_lite_regs_slv: NUM_REGS must be at least 1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    wr_state_e                 r_wr_state;
    logic                      r_aw_held;
    logic                      r_w_held;
    logic [AXI_ADDR_WIDTH-1:0] r_aw_addr;
    logic [AXI_DATA_WIDTH-1:0] r_w_data;
    logic [c_STRB_W-1:0]       r_w_strb;
    resp_t                     r_b_resp;

    rd_state_e                 r_rd_state;
    logic [AXI_DATA_WIDTH-1:0] r_r_data;
    resp_t                     r_r_resp;

    logic [AXI_DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]       r_reg_wr;

    // ------------------------------------------------------------------
    // Write channel decode
    // ------------------------------------------------------------------
    logic                      w_aw_ready;
    logic                      w_w_ready;
    logic                      w_aw_hs;
    logic                      w_w_hs;
    logic                      w_commit;
    logic [AXI_ADDR_WIDTH-1:0] w_wr_addr;
    logic [AXI_DATA_WIDTH-1:0] w_wr_data;
    logic [c_STRB_W-1:0]       w_wr_strb;
    logic [c_IDX_W-1:0]        w_wr_idx;
    logic                      w_wr_in_range;
    logic [NUM_REGS-1:0]       w_wr_hit;

    assign w_aw_ready = (r_wr_state == W_IDLE) && !r_aw_held;
    assign w_w_ready  = (r_wr_state == W_IDLE) && !r_w_held;
    assign w_aw_hs    = slv.aw_valid && w_aw_ready;
    assign w_w_hs     = slv.w_valid && w_w_ready;

    // A channel counts as available if it was parked earlier or is
    // handshaking right now; commit needs both.
    assign w_commit = (r_wr_state == W_IDLE)
                    && (r_aw_held || w_aw_hs)
                    && (r_w_held  || w_w_hs);

    assign w_wr_addr = r_aw_held ? r_aw_addr : slv.aw_addr;
    assign w_wr_data = r_w_held  ? r_w_data  : slv.w_data;
    assign w_wr_strb = r_w_held  ? r_w_strb  : slv.w_strb;

    assign w_wr_idx      = w_wr_addr[AXI_ADDR_WIDTH-1:c_ADDR_LSB];
    assign w_wr_in_range = (w_wr_idx < c_NUM_REGS_IDX);

    always_comb begin
        w_wr_hit = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            w_wr_hit[k] = w_commit && w_wr_in_range && (w_wr_idx == c_IDX_W'(k));
        end
    end

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_state <= W_IDLE;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_aw_addr  <= '0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_b_resp   <= RESP_OKAY;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (w_commit) begin
                        r_aw_held  <= 1'b0;
                        r_w_held   <= 1'b0;
                        r_b_resp   <= w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
                        r_wr_state <= W_RESP;
                    end else begin
                        if (w_aw_hs) begin
                            r_aw_held <= 1'b1;
                            r_aw_addr <= slv.aw_addr;
                        end
                        if (w_w_hs) begin
                            r_w_held <= 1'b1;
                            r_w_data <= slv.w_data;
                            r_w_strb <= slv.w_strb;
                        end
                    end
                end
                W_RESP: begin
                    if (slv.b_ready) begin
                        r_wr_state <= W_IDLE;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register array and write pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_reg_wr <= '0;
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= RST_VAL;
            end
        end else begin
            r_reg_wr <= w_wr_hit;
            for (int k = 0; k < NUM_REGS; k++) begin
                if (w_wr_hit[k]) begin
                    r_regs[k] <= AXI_DATA_WIDTH'(strb_merge(64'(r_regs[k]),
                                                            64'(w_wr_data),
                                                            8'(w_wr_strb)));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read FSM; r_regs is sampled pre-edge, so a read colliding with a
    // write to the same register returns the old contents.
    // ------------------------------------------------------------------
    logic                      w_ar_ready;
    logic                      w_ar_hs;
    logic [c_IDX_W-1:0]        w_rd_idx;
    logic                      w_rd_in_range;
    logic [AXI_DATA_WIDTH-1:0] w_rd_data;

    assign w_ar_ready    = (r_rd_state == R_IDLE);
    assign w_ar_hs       = slv.ar_valid && w_ar_ready;
    assign w_rd_idx      = slv.ar_addr[AXI_ADDR_WIDTH-1:c_ADDR_LSB];
    assign w_rd_in_range = (w_rd_idx < c_NUM_REGS_IDX);

    // No index match leaves zero, which is the out-of-range read data.
    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_rd_idx == c_IDX_W'(k)) begin
                w_rd_data = r_regs[k];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_state <= R_IDLE;
            r_r_data   <= '0;
            r_r_resp   <= RESP_OKAY;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_r_data   <= w_rd_data;
                        r_r_resp   <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
                        r_rd_state <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (slv.r_ready) begin
                        r_rd_state <= R_IDLE;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign slv.aw_ready = w_aw_ready;
    assign slv.w_ready  = w_w_ready;
    assign slv.b_valid  = (r_wr_state == W_RESP);
    assign slv.b_resp   = r_b_resp;
    assign slv.ar_ready = w_ar_ready;
    assign slv.r_valid  = (r_rd_state == R_RESP);
    assign slv.r_data   = r_r_data;
    assign slv.r_resp   = r_r_resp;
    assign reg_wr_o     = r_reg_wr;

    generate
        for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_o
            assign reg_o[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = r_regs[k];
        end
    endgenerate

    // Protection bits and byte-offset address bits carry no meaning here.
    logic w_unused;
    assign w_unused = ^{slv.aw_prot, slv.ar_prot,
                        w_wr_addr[c_ADDR_LSB-1:0], slv.ar_addr[c_ADDR_LSB-1:0]};

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_regs_slv.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_regs_slv
// Description : Self-checking bench for axi_lite_regs_slv: a transaction-level
//               register/response model plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_regs_slv;
    import axi_lite_regs_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 8;
    localparam logic [DW-1:0] RST = 32'hCAFE_F00D;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    AXI_LITE #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) bus ();
    logic [NR*DW-1:0] reg_o;
    logic [NR-1:0]    reg_wr_o;

    axi_lite_regs_slv #(
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .NUM_REGS(NR), .RST_VAL(RST)
    ) dut (
        .clk_i(clk), .rst_i(rst), .slv(bus), .reg_o(reg_o), .reg_wr_o(reg_wr_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [NR*DW-1:0] act,
                         input logic [NR*DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail_to(input string name);
        total++;
        bad++;
        $display("FAIL %s: got no handshake within budget, want handshake", name);
    endtask

    // ---------------------------------------------------------------
    // Transaction-level model: pending AW/W queues pair up into commits,
    // outstanding B/R responses queue until accepted.
    // ---------------------------------------------------------------
    logic [DW-1:0]   m_regs [NR];
    logic [AW-1:0]   awq [$];
    logic [DW+3:0]   wq  [$];
    logic [1:0]      bq  [$];
    logic [DW+1:0]   rq  [$];
    logic [NR-1:0]   m_wr;
    bit              started = 1'b0;

    always @(posedge clk) begin
        logic [AW-1:0] a;
        logic [DW+3:0] wd;
        int            idx;
        if (rst) begin
            for (int k = 0; k < NR; k++) m_regs[k] = RST;
            awq.delete(); wq.delete(); bq.delete(); rq.delete();
            m_wr = '0;
        end else begin
            m_wr = '0;
            if (bus.r_valid && bus.r_ready && rq.size() != 0) void'(rq.pop_front());
            if (bus.b_valid && bus.b_ready && bq.size() != 0) void'(bq.pop_front());
            if (bus.ar_valid && bus.ar_ready) begin
                idx = int'(bus.ar_addr >> 2);
                if (idx < NR) rq.push_back({RESP_OKAY, m_regs[idx]});
                else          rq.push_back({RESP_SLVERR, {DW{1'b0}}});
            end
            if (bus.aw_valid && bus.aw_ready) awq.push_back(bus.aw_addr);
            if (bus.w_valid && bus.w_ready)   wq.push_back({bus.w_strb, bus.w_data});
            if (awq.size() != 0 && wq.size() != 0) begin
                a   = awq.pop_front();
                wd  = wq.pop_front();
                idx = int'(a >> 2);
                if (idx < NR) begin
                    for (int b = 0; b < DW/8; b++)
                        if (wd[DW+b]) m_regs[idx][8*b +: 8] = wd[8*b +: 8];
                    m_wr[idx] = 1'b1;
                    bq.push_back(RESP_OKAY);
                end else begin
                    bq.push_back(RESP_SLVERR);
                end
            end
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        logic [NR*DW-1:0] flat;
        if (started) begin
            for (int k = 0; k < NR; k++) flat[k*DW +: DW] = m_regs[k];
            check("reg_o", reg_o, flat);
            check("reg_wr_o", reg_wr_o, m_wr);
            check("b_valid", bus.b_valid, bq.size() != 0);
            if (bq.size() != 0) check("b_resp", bus.b_resp, bq[0]);
            check("aw_ready", bus.aw_ready, bq.size() == 0 && awq.size() == 0);
            check("w_ready",  bus.w_ready,  bq.size() == 0 && wq.size() == 0);
            check("ar_ready", bus.ar_ready, rq.size() == 0);
            check("r_valid",  bus.r_valid,  rq.size() != 0);
            if (rq.size() != 0) begin
                check("r_data", bus.r_data, rq[0][DW-1:0]);
                check("r_resp", bus.r_resp, rq[0][DW+1:DW]);
            end
        end
    end

    // ---------------------------------------------------------------
    // Stimulus helpers (called at a negedge, return at a negedge)
    // ---------------------------------------------------------------
    task automatic put_aw(input logic [AW-1:0] a);
        bus.aw_addr = a; bus.aw_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bus.aw_ready) begin @(negedge clk); bus.aw_valid = 1'b0; return; end
            @(negedge clk);
        end
        bus.aw_valid = 1'b0; fail_to("aw_handshake");
    endtask

    task automatic put_w(input logic [DW-1:0] d, input logic [DW/8-1:0] s);
        bus.w_data = d; bus.w_strb = s; bus.w_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bus.w_ready) begin @(negedge clk); bus.w_valid = 1'b0; return; end
            @(negedge clk);
        end
        bus.w_valid = 1'b0; fail_to("w_handshake");
    endtask

    task automatic put_ar(input logic [AW-1:0] a);
        bus.ar_addr = a; bus.ar_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bus.ar_ready) begin @(negedge clk); bus.ar_valid = 1'b0; return; end
            @(negedge clk);
        end
        bus.ar_valid = 1'b0; fail_to("ar_handshake");
    endtask

    task automatic get_b(output logic [1:0] resp);
        resp = 2'bxx;
        for (int i = 0; i < 50; i++) begin
            if (bus.b_valid && bus.b_ready) begin resp = bus.b_resp; @(negedge clk); return; end
            @(negedge clk);
        end
        fail_to("b_handshake");
    endtask

    task automatic get_r(output logic [DW-1:0] d, output logic [1:0] resp);
        d = 'x; resp = 2'bxx;
        for (int i = 0; i < 50; i++) begin
            if (bus.r_valid && bus.r_ready) begin
                d = bus.r_data; resp = bus.r_resp; @(negedge clk); return;
            end
            @(negedge clk);
        end
        fail_to("r_handshake");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, want end of test");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------
    // Directed sequence
    // ---------------------------------------------------------------
    initial begin
        logic [1:0]    resp;
        logic [1:0]    rresp;
        logic [DW-1:0] rd;

        rst = 1'b1;
        bus.aw_valid = 1'b0; bus.aw_addr = '0; bus.aw_prot = '0;
        bus.w_valid  = 1'b0; bus.w_data  = '0; bus.w_strb  = '0;
        bus.ar_valid = 1'b0; bus.ar_addr = '0; bus.ar_prot = '0;
        bus.b_ready  = 1'b1; bus.r_ready = 1'b1;

        // 1: reset values
        repeat (2) @(negedge clk);
        check("t1_regs", reg_o, {NR{RST}});
        check("t1_flags", {bus.aw_ready, bus.w_ready, bus.ar_ready, bus.b_valid, bus.r_valid},
              5'b11100);
        rst = 1'b0;
        @(negedge clk);

        // 2: write then read reg1
        fork
            put_aw(32'h4);
            put_w(32'hDEAD_BEEF, 4'hF);
        join
        check("t2_b_latency", bus.b_valid, 1'b1);
        check("t2_pulse", reg_wr_o, 8'b0000_0010);
        get_b(resp);
        check("t2_bresp", resp, RESP_OKAY);
        put_ar(32'h4);
        get_r(rd, rresp);
        check("t2_rdata", rd, 32'hDEAD_BEEF);
        check("t2_rresp", rresp, RESP_OKAY);

        // 3: W ahead of AW with sparse strobes
        put_w(32'h1122_3344, 4'h5);
        repeat (3) begin
            check("t3_no_early_b", bus.b_valid, 1'b0);
            @(negedge clk);
        end
        put_aw(32'h0);
        get_b(resp);
        check("t3_bresp", resp, RESP_OKAY);
        check("t3_reg0", reg_o[DW-1:0], 32'hCA22_F044);

        // 4: out of range
        fork
            put_aw(32'h20);
            put_w(32'h5555_5555, 4'hF);
        join
        check("t4_no_pulse", reg_wr_o, 8'h00);
        get_b(resp);
        check("t4_bresp", resp, RESP_SLVERR);
        check("t4_regs", reg_o, {{6{RST}}, 32'hDEAD_BEEF, 32'hCA22_F044});
        put_ar(32'h20);
        get_r(rd, rresp);
        check("t4_rdata", rd, 32'h0);
        check("t4_rresp", rresp, RESP_SLVERR);

        // 5: backpressure on both response channels
        bus.b_ready = 1'b0; bus.r_ready = 1'b0;
        fork
            put_aw(32'hC);
            put_w(32'h0BAD_F00D, 4'hF);
            put_ar(32'h4);
        join
        repeat (5) begin
            check("t5_held", {bus.b_valid, bus.r_valid, bus.aw_ready, bus.w_ready, bus.ar_ready},
                  5'b11000);
            check("t5_bresp", bus.b_resp, RESP_OKAY);
            check("t5_rdata", bus.r_data, 32'hDEAD_BEEF);
            @(negedge clk);
        end
        bus.b_ready = 1'b1; bus.r_ready = 1'b1;
        @(negedge clk);
        check("t5_release", {bus.b_valid, bus.r_valid, bus.aw_ready, bus.w_ready, bus.ar_ready},
              5'b00111);
        check("t5_reg3", reg_o[3*DW +: DW], 32'h0BAD_F00D);

        // 6: same-edge read/write collision on reg2
        fork
            put_aw(32'h8);
            put_w(32'h1234_5678, 4'hF);
        join
        get_b(resp);
        fork
            put_aw(32'h8);
            put_w(32'h0000_00A5, 4'hF);
            put_ar(32'h8);
        join
        fork
            get_b(resp);
            get_r(rd, rresp);
        join
        check("t6_read_old", rd, 32'h1234_5678);
        check("t6_reg2_new", reg_o[2*DW +: DW], 32'h0000_00A5);

        // 6b: reset while a write response is pending
        bus.b_ready = 1'b0;
        fork
            put_aw(32'h10);
            put_w(32'h0000_0077, 4'hF);
        join
        check("t6_b_pending", bus.b_valid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_b_dropped", bus.b_valid, 1'b0);
        check("t6_regs_reset", reg_o, {NR{RST}});
        rst = 1'b0;
        bus.b_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_idle_after", {bus.b_valid, bus.aw_ready, bus.w_ready}, 3'b011);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
